uart_rx_ex: RTL and testbench

Parametrised UART receiver with configurable frame format, oversampled majority-vote bit detection, per-byte error tagging and a configurable-depth receive FIFO. It sits on the peripheral bus behind the same request/ready handshake as the other Rv32H peripherals. It adds a status word and sticky error flags that let firmware detect framing errors, parity errors and overruns.

---
 rtl/uart_rx_ex_if.sv | 10 +
 rtl/uart_rx_ex.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_ex.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ex_if.sv
// Request/ready read bus between a bus master and the uart_rx_ex receiver.
interface uart_rx_ex_if;
  logic        i_request;
  logic        i_address;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (output i_request, output i_address, input o_rdata, input o_ready);
  modport slave  (input i_request, input i_address, output o_rdata, output o_ready);
endinterface

// File: rtl/uart_rx_ex.sv
// Oversampled UART receiver with error-tagged RX FIFO behind a request/ready read bus.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_ex #(
  parameter int PRESCALE   = 26,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  uart_rx_ex_if.slave bus,
  input  logic        UART_RX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [15:0]   PRE_M1   = 16'(PRESCALE - 1);
  localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_ARM, ST_IDLE, ST_START, ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PAR,
`endif
    ST_STOP, ST_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [15:0]   tick_q, tick_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          s0_q, s0_d, s1_q, s1_d;
  logic          line, tick, maj, at_dec, at_end, push, fe_evt, par_tag;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, pop, do_push, ovr_evt, clr;
  logic          ovr_q, fe_q, pe_flag;
  logic          act_q, act_d, addr_q, ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = (PARITY != 0);
  logic par_err_q, par_err_d, pe_q;
  assign par_tag = par_err_q;
  assign pe_flag = pe_q;
`else
  logic unused_parity;
  assign unused_parity = (PARITY != 0);
  assign par_tag = 1'b0;
  assign pe_flag = 1'b0;
`endif

  assign line   = sync2_q;
  assign tick   = (state_q != ST_IDLE) && (tick_q == 16'd0);
  assign maj    = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
  assign at_dec = tick && (samp_q == S_DEC);
  assign at_end = tick && (samp_q == S_END);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    push    = 1'b0;
    fe_evt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (state_q == ST_IDLE || tick_q == 16'd0) tick_d = PRE_M1;
    else tick_d = tick_q - 16'd1;
    if (tick) begin
      samp_d = (samp_q == S_END) ? '0 : samp_q + SW'(1);
      if (samp_q == S_LO)  s0_d = line;
      if (samp_q == S_MID) s1_d = line;
    end
    case (state_q)
      ST_ARM: if (line) state_d = ST_IDLE;
      ST_IDLE: begin
        if (prev_q && !line) begin
          state_d = ST_START;
          samp_d  = '0;
          tick_d  = PRE_M1;
          shift_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (at_dec && maj) state_d = ST_IDLE;
        else if (at_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_dec) shift_d[bit_q] = maj;
        if (at_end) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PAR_ON ? ST_PAR : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PAR: begin
        // Odd parity expects a set XOR over data+parity, even expects clear.
        if (at_dec) par_err_d = (^shift_q) ^ maj ^ (PARITY == 1);
        if (at_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leave at the decision point so a start bit right after the stop bit is seen.
        if (at_dec) begin
          if (maj) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_evt  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: if (line) state_d = ST_IDLE;
      default:  state_d = ST_ARM;
    endcase
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pop     = act_q && !addr_q && !empty;
  assign clr     = act_q && addr_q;
  assign do_push = push && (!full || pop);
  assign ovr_evt = push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  assign act_d   = bus.i_request && !act_q && !ready_q;
  assign ready_d = act_q ? 1'b1 : (bus.i_request ? ready_q : 1'b0);

  always_comb begin
    rdata_d = rdata_q;
    if (act_q) begin
      if (addr_q) rdata_d = {16'(cnt_q), 12'b0, ovr_q, pe_flag, fe_q, empty};
      else if (empty) rdata_d = 32'h8000_0000;
      else rdata_d = {22'b0, mem_q[rd_q]};
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem_q[wr_q] <= {par_tag, shift_q};
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= ST_ARM;
      tick_q  <= PRE_M1;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      act_q   <= 1'b0;
      addr_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      sync1_q <= UART_RX;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      if (do_push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      ovr_q   <= (ovr_q & ~clr) | ovr_evt;
      fe_q    <= (fe_q & ~clr) | fe_evt;
      act_q   <= act_d;
      if (act_d) addr_q <= bus.i_address;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      pe_q      <= (pe_q & ~clr) | (push & par_tag);
`endif
    end
  end

  assign bus.o_rdata = rdata_q;
  assign bus.o_ready = ready_q;
endmodule

// File: tb/tb_uart_rx_ex.sv
// Directed bench for uart_rx_ex: queue-based receive model plus literal expectations.
module tb_uart_rx_ex;
  localparam int BT0 = 64;  // dut0: PRESCALE 4 x OVERSAMPLE 16
  localparam int BT1 = 24;  // dut1: PRESCALE 3 x OVERSAMPLE 8
`ifdef UART_RX_PARITY_EN
  localparam int P1 = 1;
`else
  localparam int P1 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, line0, line1;
  uart_rx_ex_if bus0();
  uart_rx_ex_if bus1();

  uart_rx_ex #(.PRESCALE(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus0), .UART_RX(line0));
  uart_rx_ex #(.PRESCALE(3), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(2)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus1), .UART_RX(line1));

  logic [9:0]  mq0[$], mq1[$];
  int          depth [2] = '{4, 2};
  bit          m_ovr [2], m_pe [2], m_fe [2];
  logic [31:0] exp_rd [2];
  bit          armed [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic int m_size(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic m_reset();
    mq0.delete(); mq1.delete();
    for (int i = 0; i < 2; i++) begin m_ovr[i] = 0; m_pe[i] = 0; m_fe[i] = 0; end
  endtask

  task automatic m_push(input int d, input logic [9:0] v);
    if (v[9]) m_pe[d] = 1;
    if (m_size(d) >= depth[d]) m_ovr[d] = 1;
    else if (d == 0) mq0.push_back(v);
    else mq1.push_back(v);
  endtask

  task automatic m_read(input int d, input logic addr, output logic [31:0] e);
    int n;
    n = m_size(d);
    if (addr) begin
      e = {16'(n), 12'b0, m_ovr[d], m_pe[d], m_fe[d], (n == 0)};
      m_ovr[d] = 0; m_pe[d] = 0; m_fe[d] = 0;
    end else if (n == 0) e = 32'h8000_0000;
    else e = {22'b0, (d == 0) ? mq0.pop_front() : mq1.pop_front()};
  endtask

  always @(negedge clk) begin
    if (armed[0] && bus0.o_ready) chk("model_rd0", bus0.o_rdata, exp_rd[0]);
    if (armed[1] && bus1.o_ready) chk("model_rd1", bus1.o_rdata, exp_rd[1]);
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? bus0.o_ready : bus1.o_ready;
  endfunction

  task automatic set_req(input int d, input logic r, input logic a);
    if (d == 0) begin bus0.i_request = r; bus0.i_address = a; end
    else begin bus1.i_request = r; bus1.i_address = a; end
  endtask

  // Called on a negedge; request is sampled at the next posedge (cycle N).
  task automatic bus_read(input int d, input logic addr, input string name, output logic [31:0] got);
    logic [31:0] e;
    m_read(d, addr, e);
    exp_rd[d] = e;
    armed[d] = 1;
    set_req(d, 1'b1, addr);
    @(negedge clk); chk({name, "_rdy_n1"}, 32'(rdy(d)), 32'd0);
    @(negedge clk); chk({name, "_rdy_n2"}, 32'(rdy(d)), 32'd1);
    got = (d == 0) ? bus0.o_rdata : bus1.o_rdata;
    repeat (2) @(negedge clk);
    set_req(d, 1'b0, 1'b0);
    @(negedge clk);
    armed[d] = 0;
    chk({name, "_rdy_drop"}, 32'(rdy(d)), 32'd0);
  endtask

  task automatic hold(input int d, input logic v, input int cyc);
    if (d == 0) line0 = v; else line1 = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [8:0] dat, input int has_par,
                            input logic pbit, input int stop_low);
    int bt, nb;
    logic tag;
    bt = (d == 0) ? BT0 : BT1;
    nb = (d == 0) ? 8 : 7;
    hold(d, 1'b0, bt);
    for (int i = 0; i < nb; i++) hold(d, dat[i], bt);
    if (has_par != 0) hold(d, pbit, bt);
    if (stop_low > 0) begin
      hold(d, 1'b0, bt * stop_low);
      hold(d, 1'b1, bt);
      m_fe[d] = 1;
    end else begin
      hold(d, 1'b1, bt);
      tag = (has_par != 0) ? ((^dat[6:0]) ^ pbit) : 1'b0;
      m_push(d, {tag, dat});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; line0 = 1'b1; line1 = 1'b1;
    set_req(0, 1'b0, 1'b0); set_req(1, 1'b0, 1'b0);
    armed[0] = 0; armed[1] = 0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_rdata0", bus0.o_rdata, 32'd0);
    chk("rst_ready0", 32'(bus0.o_ready), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(0, 1'b1, "rst_status0", r); chk("rst_status0_lit", r, 32'h0000_0001);

    send_frame(0, 9'h055, 0, 1'b0, 0);
    send_frame(0, 9'h0A3, 0, 1'b0, 0);
    bus_read(0, 1'b1, "b2b_status", r); chk("b2b_status_lit", r, 32'h0002_0000);
    bus_read(0, 1'b0, "b2b_rd0", r);    chk("b2b_rd0_lit", r, 32'h0000_0055);
    bus_read(0, 1'b0, "b2b_rd1", r);    chk("b2b_rd1_lit", r, 32'h0000_00A3);
    bus_read(0, 1'b0, "empty_rd", r);   chk("empty_rd_lit", r, 32'h8000_0000);

    hold(0, 1'b0, 10);
    hold(0, 1'b1, 3 * BT0);
    bus_read(0, 1'b1, "glitch_status", r); chk("glitch_status_lit", r, 32'h0000_0001);

    send_frame(0, 9'h03C, 0, 1'b0, 2);
    send_frame(0, 9'h011, 0, 1'b0, 0);
    bus_read(0, 1'b1, "fe_status", r);  chk("fe_status_lit", r, 32'h0001_0002);
    bus_read(0, 1'b0, "fe_rd", r);      chk("fe_rd_lit", r, 32'h0000_0011);
    bus_read(0, 1'b1, "fe_status2", r); chk("fe_status2_lit", r, 32'h0000_0001);

    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 0, 1'b0, 0);
    bus_read(0, 1'b1, "ovr_status", r); chk("ovr_status_lit", r, 32'h0004_0008);
    for (int i = 1; i <= 4; i++) begin
      bus_read(0, 1'b0, "ovr_rd", r); chk("ovr_rd_lit", r, 32'(i));
    end

    // Push lands 619 cycles after the start edge; time the pop cycle onto it.
    for (int i = 6; i <= 9; i++) send_frame(0, 9'(i), 0, 1'b0, 0);
    fork
      send_frame(0, 9'h00A, 0, 1'b0, 0);
      begin
        repeat (617) @(negedge clk);
        bus_read(0, 1'b0, "same_rd", r);
      end
    join
    chk("same_rd_lit", r, 32'h0000_0006);
    bus_read(0, 1'b1, "same_status", r); chk("same_status_lit", r, 32'h0004_0000);
    for (int i = 7; i <= 10; i++) begin
      bus_read(0, 1'b0, "same_drain", r); chk("same_drain_lit", r, 32'(i));
    end

    // 0x77: start, bits0..2 high, reset during bit3 (low).
    hold(0, 1'b0, BT0);
    hold(0, 1'b1, 3 * BT0);
    hold(0, 1'b0, 20);
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("midrst_rdata", bus0.o_rdata, 32'd0);
    chk("midrst_ready", 32'(bus0.o_ready), 32'd0);
    rst_n = 1'b1;
    hold(0, 1'b0, 40);
    hold(0, 1'b1, 2 * BT0);
    bus_read(0, 1'b1, "midrst_status", r); chk("midrst_status_lit", r, 32'h0000_0001);
    send_frame(0, 9'h012, 0, 1'b0, 0);
    bus_read(0, 1'b0, "midrst_rd", r); chk("midrst_rd_lit", r, 32'h0000_0012);

    send_frame(1, 9'h07F, P1, 1'b1, 0);
    send_frame(1, 9'h000, P1, 1'b0, 0);
    send_frame(1, 9'h02A, P1, 1'b1, 0);
    bus_read(1, 1'b1, "d1_status", r); chk("d1_status_lit", r, 32'h0002_0008);
    bus_read(1, 1'b0, "d1_rd0", r);    chk("d1_rd0_lit", r, 32'h0000_007F);
    bus_read(1, 1'b0, "d1_rd1", r);    chk("d1_rd1_lit", r, 32'h0000_0000);
    bus_read(1, 1'b0, "d1_empty", r);  chk("d1_empty_lit", r, 32'h8000_0000);

`ifdef UART_RX_PARITY_EN
    send_frame(1, 9'h041, 1, 1'b0, 0);
    send_frame(1, 9'h041, 1, 1'b1, 0);
    bus_read(1, 1'b0, "par_rd0", r);    chk("par_rd0_lit", r, 32'h0000_0041);
    bus_read(1, 1'b0, "par_rd1", r);    chk("par_rd1_lit", r, 32'h0000_0241);
    bus_read(1, 1'b1, "par_status", r); chk("par_status_lit", r, 32'h0000_0005);
`else
    send_frame(1, 9'h041, 0, 1'b0, 0);
    send_frame(1, 9'h041, 0, 1'b0, 0);
    bus_read(1, 1'b0, "nopar_rd0", r);    chk("nopar_rd0_lit", r, 32'h0000_0041);
    bus_read(1, 1'b0, "nopar_rd1", r);    chk("nopar_rd1_lit", r, 32'h0000_0041);
    bus_read(1, 1'b1, "nopar_status", r); chk("nopar_status_lit", r, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
